niski_dut_top: RTL and testbench

Board-level top of the Niski demo design, simulated stand-alone on a 25 MHz clock. Wires five buttons, four LEDs, a 4-digit multiplexed seven-segment display and an HD44780-compatible 8-bit character LCD. After reset it initialises the LCD and writes a fixed banner. It also runs a free-running hex counter on the seven-segment display and mirrors buttons onto LEDs.

---
 rtl/niski_pkg.sv | 26 ++
 rtl/lcd_controller.sv | 70 +++++++
 rtl/niski_dut_top.sv | 96 +++++++++
 tb/tb_niski_dut_top.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/niski_pkg.sv
// niski_pkg: LCD FSM states, LCD script contents and seven-segment glyphs
package niski_pkg;
  typedef enum logic [2:0] {POWERUP, SETUP, PULSE, HOLD, WAIT, NEXT, DONE} lcd_state_t;
  localparam logic [7:0] FUNC_SET_8BIT = 8'h38;
  localparam logic [7:0] DISP_ON = 8'h0C;
  localparam logic [7:0] ENTRY_INC = 8'h06;
  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] DDRAM_LINE0 = 8'h80;
  localparam int SCRIPT_LEN = 17;
  localparam logic [7:0] COMMANDS [5] = '{FUNC_SET_8BIT, DISP_ON, ENTRY_INC, CLEAR, DDRAM_LINE0};
  localparam logic [7:0] BANNER [12] = '{8'h4E, 8'h69, 8'h73, 8'h6B, 8'h69, 8'h20,
                                         8'h52, 8'h49, 8'h53, 8'h43, 8'h2D, 8'h56};
  localparam logic [6:0] GLYPHS [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // {rs, byte} of script step i: five commands, then the banner as data
  function automatic logic [8:0] script_entry(input logic [4:0] i);
    logic [3:0] b;
    b = 4'(i - 5'd5);
    return i < 5'd5 ? {1'b0, COMMANDS[i[2:0]]} : {1'b1, BANNER[b]};
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    return GLYPHS[h];
  endfunction
endpackage

// File: rtl/lcd_controller.sv
// lcd_controller: runs the fixed HD44780 init + banner script once after reset
module lcd_controller
  import niski_pkg::*;
#(
  parameter int unsigned PWR_CYC = 375_000,
  parameter int unsigned CMD_CYC = 1_250,
  parameter int unsigned CLR_CYC = 50_000,
  parameter int unsigned E_CYC = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       rs,
  output logic       e,
  output logic [7:0] data
);
  lcd_state_t state;
  logic [31:0] cnt;
  logic [4:0] idx;
  logic [31:0] wait_cyc;

  assign wait_cyc = (!rs && data == CLEAR) ? CLR_CYC : CMD_CYC;

  // script sequencer; bus and strobe are registered so E never glitches
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= POWERUP;
      cnt <= '0;
      idx <= '0;
      rs <= 1'b0;
      e <= 1'b0;
      data <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      case (state)
        POWERUP: if (cnt == PWR_CYC - 1) begin
          state <= SETUP;
          cnt <= '0;
          {rs, data} <= script_entry(idx);
        end
        SETUP: if (cnt == 32'd1) begin
          state <= PULSE;
          cnt <= '0;
          e <= 1'b1;
        end
        PULSE: if (cnt == E_CYC - 1) begin
          state <= HOLD;
          cnt <= '0;
          e <= 1'b0;
        end
        HOLD: if (cnt == 32'd1) begin
          state <= WAIT;
          cnt <= '0;
        end
        WAIT: if (cnt == wait_cyc - 1) begin
          state <= NEXT;
          cnt <= '0;
        end
        NEXT: begin
          cnt <= '0;
          idx <= idx + 5'd1;
          if (idx == 5'(SCRIPT_LEN - 1)) state <= DONE;
          else begin
            state <= SETUP;
            {rs, data} <= script_entry(idx + 5'd1);
          end
        end
        default: cnt <= '0;
      endcase
    end
endmodule

// File: rtl/niski_dut_top.sv
// niski_dut_top: board top; reset sync, LEDs, LCD script, hex counter display (NISKI_SEVSEG_EN)
module niski_dut_top
  import niski_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 25_000_000,
  parameter int unsigned LCD_POWERUP_US = 15_000,
  parameter int unsigned LCD_CMD_US = 50,
  parameter int unsigned LCD_CLEAR_US = 2_000,
  parameter int unsigned LCD_E_CYCLES = 12
`ifdef NISKI_SEVSEG_EN
  ,
  parameter int unsigned SSD_REFRESH_HZ = 1_000,
  parameter int unsigned COUNT_HZ = 10
`endif
) (
  input  logic       CLK_PIN,
  input  logic [4:0] BTN_PINS,
  output logic [3:0] LED_PINS,
  output logic [6:0] SEVSEG_SEG_PINS,
  output logic [3:0] SEVSEG_SEL_PINS,
  output logic       LCD_RS_PIN,
  output logic       LCD_RW_PIN,
  output logic       LCD_E_PIN,
  output logic [7:0] LCD_DATA_PINS
);
  localparam int unsigned PWR_CYC = 32'(64'(CLK_FREQ_HZ) * 64'(LCD_POWERUP_US) / 64'd1_000_000);
  localparam int unsigned CMD_CYC = 32'(64'(CLK_FREQ_HZ) * 64'(LCD_CMD_US) / 64'd1_000_000);
  localparam int unsigned CLR_CYC = 32'(64'(CLK_FREQ_HZ) * 64'(LCD_CLEAR_US) / 64'd1_000_000);

  logic [1:0] rst_sync;
  logic rst_n;

  // assert at once, release after two clean clock edges
  always_ff @(posedge CLK_PIN or negedge BTN_PINS[4])
    if (!BTN_PINS[4]) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};

  assign rst_n = rst_sync[1];
  assign LCD_RW_PIN = 1'b0;

  // buttons mirrored onto LEDs through one register
  always_ff @(posedge CLK_PIN or negedge rst_n)
    if (!rst_n) LED_PINS <= '0;
    else LED_PINS <= BTN_PINS[3:0];

  lcd_controller #(
    .PWR_CYC(PWR_CYC),
    .CMD_CYC(CMD_CYC),
    .CLR_CYC(CLR_CYC),
    .E_CYC(LCD_E_CYCLES)
  ) u_lcd (
    .clk(CLK_PIN),
    .rst_n(rst_n),
    .rs(LCD_RS_PIN),
    .e(LCD_E_PIN),
    .data(LCD_DATA_PINS)
  );

`ifdef NISKI_SEVSEG_EN
  localparam int unsigned COUNT_DIV = CLK_FREQ_HZ / COUNT_HZ;
  localparam int unsigned SCAN_DIV = CLK_FREQ_HZ / SSD_REFRESH_HZ;

  logic [15:0] count;
  logic [31:0] cnt_div;
  logic [31:0] scan_div;
  logic [1:0] digit;

  // free-running divider; clear wins over increment, hold only skips the tick
  always_ff @(posedge CLK_PIN or negedge rst_n)
    if (!rst_n) begin
      cnt_div <= '0;
      count <= '0;
    end else begin
      cnt_div <= cnt_div == COUNT_DIV - 1 ? '0 : cnt_div + 32'd1;
      if (BTN_PINS[1]) count <= '0;
      else if (cnt_div == COUNT_DIV - 1 && !BTN_PINS[0]) count <= count + 16'd1;
    end

  // digit scan with registered segment and select drive
  always_ff @(posedge CLK_PIN or negedge rst_n)
    if (!rst_n) begin
      scan_div <= '0;
      digit <= '0;
      SEVSEG_SEG_PINS <= 7'h7F;
      SEVSEG_SEL_PINS <= 4'hF;
    end else begin
      scan_div <= scan_div == SCAN_DIV - 1 ? '0 : scan_div + 32'd1;
      if (scan_div == SCAN_DIV - 1) digit <= digit + 2'd1;
      SEVSEG_SEG_PINS <= hex_to_seg(count[{digit, 2'b00} +: 4]);
      SEVSEG_SEL_PINS <= ~(4'b0001 << digit);
    end
`else
  assign SEVSEG_SEG_PINS = 7'h7F;
  assign SEVSEG_SEL_PINS = 4'hF;
`endif
endmodule

// File: tb/tb_niski_dut_top.sv
// tb_niski_dut_top: randomized self-checking bench for the Niski board top (scaled timing)
module tb_niski_dut_top;
  localparam int CLK_HZ = 1_000_000;
  localparam int PWR_US = 200, CMD_US = 5, CLR_US = 40, EW = 12;
  localparam int PWR = CLK_HZ / 1_000_000 * PWR_US;
  localparam int CMD = CLK_HZ / 1_000_000 * CMD_US;
  localparam int CLR = CLK_HZ / 1_000_000 * CLR_US;
  localparam int SCAN = CLK_HZ / 100_000;
  localparam int CNT = CLK_HZ / 20_000;

  logic clk = 1'b0;
  logic [4:0] btn = 5'b10000;
  logic [3:0] led;
  logic [6:0] seg;
  logic [3:0] sel;
  logic rs, rw, e;
  logic [7:0] data;

  int vectors = 0, errors = 0, cyc = 0;
  int rel;

  niski_dut_top #(
    .CLK_FREQ_HZ(CLK_HZ),
    .LCD_POWERUP_US(PWR_US),
    .LCD_CMD_US(CMD_US),
    .LCD_CLEAR_US(CLR_US),
    .LCD_E_CYCLES(EW)
`ifdef NISKI_SEVSEG_EN
    ,
    .SSD_REFRESH_HZ(100_000),
    .COUNT_HZ(20_000)
`endif
  ) dut (
    .CLK_PIN(clk),
    .BTN_PINS(btn),
    .LED_PINS(led),
    .SEVSEG_SEG_PINS(seg),
    .SEVSEG_SEL_PINS(sel),
    .LCD_RS_PIN(rs),
    .LCD_RW_PIN(rw),
    .LCD_E_PIN(e),
    .LCD_DATA_PINS(data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [8:0] exp_entry(input int i);
    logic [7:0] cmds [5] = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h80};
    string banner = "Niski RISC-V";
    return i < 5 ? {1'b0, cmds[i]} : {1'b1, 8'(banner[i-5])};
  endfunction

  logic mon = 1'b0, pe = 1'b0;
  logic [8:0] pbus = '0;
  int chg = 0, rise = 0, fall = -100;
  int q_cyc[$];
  logic [8:0] q_bus[$];

  always @(negedge clk) begin
    if (mon) begin
      if ({rs, data} != pbus) begin
        chg = cyc;
        expect_eq("bus_hold", 32'(!e && (cyc - fall >= 2)), 1);
      end
      if (e && !pe) begin
        rise = cyc;
        q_cyc.push_back(cyc);
        q_bus.push_back({rs, data});
        expect_eq("bus_setup", 32'(cyc - chg >= 2), 1);
      end
      if (!e && pe) begin
        fall = cyc;
        expect_eq("e_width", cyc - rise, EW);
      end
    end
    pe = e;
    pbus = {rs, data};
  end

  task automatic check_reset_outputs(input string tag);
    expect_eq({tag, "_led"}, led, 0);
    expect_eq({tag, "_seg"}, seg, 7'h7F);
    expect_eq({tag, "_sel"}, sel, 4'hF);
    expect_eq({tag, "_rs"}, rs, 0);
    expect_eq({tag, "_rw"}, rw, 0);
    expect_eq({tag, "_e"}, e, 0);
    expect_eq({tag, "_data"}, data, 0);
  endtask

  task automatic release_reset();
    q_cyc.delete();
    q_bus.delete();
    fall = -100;
    btn[4] = 1'b1;
    rel = cyc;
    mon = 1'b1;
  endtask

  task automatic lcd_phase();
    int n = 0;
    int lo;
    logic [3:0] v;
    repeat (4) @(negedge clk);
    while (q_bus.size() < 17 && n < 3000) begin
      v = 4'($urandom);
      btn[3:0] = v;
      @(negedge clk);
      expect_eq("led", led, v);
      n++;
    end
    expect_eq("script_in_budget", 32'(q_bus.size() >= 17), 1);
    for (int i = 0; i < q_bus.size() && i < 17; i++)
      expect_eq($sformatf("byte%0d", i), q_bus[i], exp_entry(i));
    if (q_bus.size() > 0) expect_eq("first_rise", q_cyc[0] - rel, PWR + 4);
    for (int i = 1; i < q_bus.size() && i < 17; i++) begin
      lo = exp_entry(i - 1) == 9'h001 ? CLR : CMD;
      expect_eq($sformatf("gap%0d", i),
                32'(q_cyc[i] - q_cyc[i-1] >= lo && q_cyc[i] - q_cyc[i-1] <= lo + 32), 1);
    end
    repeat (300) @(negedge clk);
    expect_eq("no_extra_edges", q_bus.size(), 17);
    expect_eq("done_bus", {rs, data}, 9'h156);
    expect_eq("done_e", e, 0);
  endtask

  initial begin
    int k;
    #500_000;
    $display("FAIL watchdog: timeout at cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    logic [3:0] s, ps;
    int last;
    #1 btn[4] = 1'b0;
    #1 check_reset_outputs("por");
    #1 release_reset();
    lcd_phase();

    @(negedge clk);
    mon = 1'b0;
    btn[4] = 1'b0;
    #1 check_reset_outputs("rst2");
    repeat ($urandom_range(1, 5)) @(negedge clk);
    #2 release_reset();
    k = $urandom_range(2, 12);
    for (int n = 0; n < 3000 && q_bus.size() < k; n++) @(negedge clk);
    repeat ($urandom_range(1, EW - 3)) @(negedge clk);
    expect_eq("e_high_before_abort", e, 1);
    #2 mon = 1'b0;
    btn[4] = 1'b0;
    #1 expect_eq("abort_e", e, 0);
    expect_eq("abort_data", data, 0);
    repeat ($urandom_range(1, 5)) @(negedge clk);
    #2 release_reset();
    lcd_phase();

    @(negedge clk);
    btn[3:0] = 4'b1010;
    @(negedge clk);
    expect_eq("led_1010", led, 4'b1010);

`ifdef NISKI_SEVSEG_EN
    btn[3:0] = 4'b0010;
    repeat (2 * CNT) @(negedge clk);
    btn[3:0] = 4'b0001;
    ps = sel;
    last = cyc;
    for (int n = 0; n < 8 * SCAN; n++) begin
      @(negedge clk);
      s = sel;
      expect_eq("sel_legal", 32'(s == 4'hE || s == 4'hD || s == 4'hB || s == 4'h7), 1);
      expect_eq("seg_cleared", seg, 7'h40);
      if (s != ps) begin
        expect_eq("sel_order", s, {ps[2:0], ps[3]});
        if (n > SCAN) expect_eq("sel_dwell", cyc - last, SCAN);
        last = cyc;
      end
      ps = s;
    end
    btn[3:0] = 4'b0000;
    repeat (3 * CNT) @(negedge clk);
    btn[3:0] = 4'b0001;
    repeat (8 * SCAN) begin
      @(negedge clk);
      expect_eq(sel == 4'hE ? "digit0_three" : "digit_hi_zero", seg, sel == 4'hE ? 7'h30 : 7'h40);
    end
`else
    repeat (5) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      expect_eq("seg_off", seg, 7'h7F);
      expect_eq("sel_off", sel, 4'hF);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
